// File: rtl/apb_sevenseg.sv
// APB slave driving an 8-digit multiplexed common-anode seven-segment display.
// Optional macro SEVENSEG_BRIGHTNESS_EN adds the BRIGHT register (0x0C) and per-slot dimming.
module apb_sevenseg #(
   parameter int DW       = 32,
   parameter int AW       = 32,
   parameter int SCAN_DIV = 100000
) (
   input  logic          pCLK,
   input  logic          pRESET,
   input  logic [AW-1:0] pADDR,
   input  logic          pSEL,
   input  logic          pENABLE,
   input  logic          pWRITE,
   input  logic [DW-1:0] pWDATA,
   output logic [DW-1:0] pRDATA,
   output logic          pREADY,
   output logic          pSLVERR,
   output logic [7:0]    an,
   output logic [6:0]    seg,
   output logic          dp
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);

   logic [DW-1:0] data_reg;
   logic [7:0]    ctrl_reg;
   logic [7:0]    dp_reg;
   logic [CW-1:0] div_cnt_reg;
   logic [2:0]    idx_reg;
   logic [7:0]    an_reg;
   logic [6:0]    seg_reg;
   logic          dp_out_reg;

   logic          acc, wr, rd;
   logic [6:0]    offset;
   logic          sel_data, sel_ctrl, sel_dp, sel_bright, valid;
   logic          lit;
   logic [3:0]    nib [8];
   logic [3:0]    cur_nib;
   logic [6:0]    hex_seg;
   logic          unused_addr;

   assign pREADY   = 1'b1;
   assign acc      = pSEL & pENABLE & pREADY;
   assign wr       = acc & pWRITE;
   assign rd       = acc & ~pWRITE;
   assign offset   = pADDR[6:0];
   assign sel_data = (offset == 7'h00);
   assign sel_ctrl = (offset == 7'h04);
   assign sel_dp   = (offset == 7'h08);
   assign valid    = sel_data | sel_ctrl | sel_dp | sel_bright;
   assign pSLVERR  = acc & ~valid;
   assign unused_addr = ^pADDR[AW-1:7];

`ifdef SEVENSEG_BRIGHTNESS_EN
   // Sub-phase counter runs in lockstep with div_cnt so that sub = div_cnt / SUB_LEN
   // without a hardware divider; both wrap together since SCAN_DIV = 16 * SUB_LEN.
   localparam int SUB_LEN = SCAN_DIV / 16;
   localparam int SW = (SUB_LEN > 1) ? $clog2(SUB_LEN) : 1;
   localparam logic [SW-1:0] SUB_LAST = SW'(SUB_LEN - 1);

   logic [3:0]    bright_reg;
   logic [SW-1:0] sub_cnt_reg;
   logic [3:0]    sub_reg;

   assign sel_bright = (offset == 7'h0C);
   assign lit        = (sub_reg <= bright_reg);

   always_ff @(posedge pCLK) begin
      if (pRESET) begin
         bright_reg  <= 4'hF;
         sub_cnt_reg <= '0;
         sub_reg     <= '0;
      end else begin
         if (wr && sel_bright)
            bright_reg <= pWDATA[3:0];
         if (sub_cnt_reg == SUB_LAST) begin
            sub_cnt_reg <= '0;
            sub_reg     <= sub_reg + 4'd1;
         end else begin
            sub_cnt_reg <= sub_cnt_reg + 1'b1;
         end
      end
   end
`else
   assign sel_bright = 1'b0;
   assign lit        = 1'b1;
`endif

   always_comb begin
      pRDATA = '0;
      if (rd) begin
         if (sel_data)
            pRDATA = data_reg;
         else if (sel_ctrl)
            pRDATA = {{(DW-8){1'b0}}, ctrl_reg};
         else if (sel_dp)
            pRDATA = {{(DW-8){1'b0}}, dp_reg};
`ifdef SEVENSEG_BRIGHTNESS_EN
         else if (sel_bright)
            pRDATA = {{(DW-4){1'b0}}, bright_reg};
`endif
      end
   end

   always_ff @(posedge pCLK) begin
      if (pRESET) begin
         data_reg <= '0;
         ctrl_reg <= '0;
         dp_reg   <= '0;
      end else if (wr) begin
         if (sel_data)
            data_reg <= pWDATA;
         if (sel_ctrl)
            ctrl_reg <= pWDATA[7:0];
         if (sel_dp)
            dp_reg <= pWDATA[7:0];
      end
   end

   always_ff @(posedge pCLK) begin
      if (pRESET) begin
         div_cnt_reg <= '0;
         idx_reg     <= '0;
      end else if (div_cnt_reg == DIV_LAST) begin
         div_cnt_reg <= '0;
         idx_reg     <= idx_reg + 3'd1;
      end else begin
         div_cnt_reg <= div_cnt_reg + 1'b1;
      end
   end

   for (genvar gi = 0; gi < 8; gi++) begin : g_nib
      assign nib[gi] = data_reg[4*gi +: 4];
   end

   assign cur_nib = nib[idx_reg];

   always_comb begin
      hex_seg = 7'h7F;
      case (cur_nib)
         4'h0: hex_seg = 7'h40;
         4'h1: hex_seg = 7'h79;
         4'h2: hex_seg = 7'h24;
         4'h3: hex_seg = 7'h30;
         4'h4: hex_seg = 7'h19;
         4'h5: hex_seg = 7'h12;
         4'h6: hex_seg = 7'h02;
         4'h7: hex_seg = 7'h78;
         4'h8: hex_seg = 7'h00;
         4'h9: hex_seg = 7'h10;
         4'hA: hex_seg = 7'h08;
         4'hB: hex_seg = 7'h03;
         4'hC: hex_seg = 7'h46;
         4'hD: hex_seg = 7'h21;
         4'hE: hex_seg = 7'h06;
         4'hF: hex_seg = 7'h0E;
         default: hex_seg = 7'h7F;
      endcase
   end

   // Pins are registered so at most one anode is ever low and a reset blanks on the next edge.
   always_ff @(posedge pCLK) begin
      if (pRESET) begin
         an_reg     <= 8'hFF;
         seg_reg    <= 7'h7F;
         dp_out_reg <= 1'b1;
      end else if (ctrl_reg[idx_reg] && lit) begin
         an_reg     <= ~(8'd1 << idx_reg);
         seg_reg    <= hex_seg;
         dp_out_reg <= ~dp_reg[idx_reg];
      end else begin
         an_reg     <= 8'hFF;
         seg_reg    <= 7'h7F;
         dp_out_reg <= 1'b1;
      end
   end

   assign an  = an_reg;
   assign seg = seg_reg;
   assign dp  = dp_out_reg;

endmodule

// File: tb/tb_apb_sevenseg.sv
// Self-checking bench for apb_sevenseg: directed APB/scan checks plus random register
// contents compared against a frame-level display model derived from cycle count.
module tb_apb_sevenseg;

`ifdef SEVENSEG_BRIGHTNESS_EN
   localparam int SD = 32;
`else
   localparam int SD = 16;
`endif
   localparam int FRAME = 8 * SD;

   logic        pCLK = 1'b0;
   logic        pRESET;
   logic [31:0] pADDR;
   logic        pSEL, pENABLE, pWRITE;
   logic [31:0] pWDATA;
   logic [31:0] pRDATA;
   logic        pREADY, pSLVERR;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int total = 0;
   int bad   = 0;
   int n     = 0;

   logic [31:0] m_data;
   logic [7:0]  m_ctrl, m_dp;
   logic [3:0]  m_bright;
   logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   apb_sevenseg #(.DW(32), .AW(32), .SCAN_DIV(SD)) dut (
      .pCLK(pCLK), .pRESET(pRESET), .pADDR(pADDR), .pSEL(pSEL), .pENABLE(pENABLE),
      .pWRITE(pWRITE), .pWDATA(pWDATA), .pRDATA(pRDATA), .pREADY(pREADY),
      .pSLVERR(pSLVERR), .an(an), .seg(seg), .dp(dp)
   );

   always #5 pCLK = ~pCLK;

   // Edges elapsed since the last reset edge.
   always @(posedge pCLK) begin
      if (pRESET) n <= 0;
      else        n <= n + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_data = 0; m_ctrl = 0; m_dp = 0; m_bright = 4'hF;
   endtask

   // Expected {an,seg,dp} after cyc edges: pins show the scan position of the previous edge.
   function automatic logic [15:0] exp_disp(int cyc);
      int q, i, d;
      bit lit;
      if (cyc == 0) return {8'hFF, 7'h7F, 1'b1};
      q = (cyc - 1) % FRAME;
      i = q / SD;
      d = q % SD;
      lit = 1'b1;
`ifdef SEVENSEG_BRIGHTNESS_EN
      lit = ((d / (SD / 16)) <= int'(m_bright));
`endif
      if (m_ctrl[i] && lit)
         return {8'(255 - (1 << i)), hex_tab[m_data[4*i +: 4]], ~m_dp[i]};
      return {8'hFF, 7'h7F, 1'b1};
   endfunction

   function automatic bit off_valid(logic [6:0] off);
`ifdef SEVENSEG_BRIGHTNESS_EN
      return off == 7'h00 || off == 7'h04 || off == 7'h08 || off == 7'h0C;
`else
      return off == 7'h00 || off == 7'h04 || off == 7'h08;
`endif
   endfunction

   function automatic logic [31:0] model_val(logic [6:0] off);
      case (off)
         7'h00: return m_data;
         7'h04: return {24'h0, m_ctrl};
         7'h08: return {24'h0, m_dp};
`ifdef SEVENSEG_BRIGHTNESS_EN
         7'h0C: return {28'h0, m_bright};
`endif
         default: return 32'h0;
      endcase
   endfunction

   task automatic apb(input logic w, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rdv, output logic err);
      @(negedge pCLK);
      pSEL = 1'b1; pENABLE = 1'b0; pWRITE = w; pADDR = addr; pWDATA = wd;
      @(negedge pCLK);
      pENABLE = 1'b1;
      #1;
      rdv = pRDATA;
      err = pSLVERR;
      @(negedge pCLK);
      pSEL = 1'b0; pENABLE = 1'b0; pWRITE = 1'b0;
      $display("apb %s addr=%h wdata=%h rdata=%h slverr=%b", w ? "WR" : "RD", addr, wd, rdv, err);
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] wd);
      logic [31:0] rdv;
      logic err;
      apb(1'b1, addr, wd, rdv, err);
      chk($sformatf("wr_err@%h", addr[6:0]), {31'h0, err}, {31'h0, !off_valid(addr[6:0])});
      chk($sformatf("wr_rdata@%h", addr[6:0]), rdv, 32'h0);
      case (addr[6:0])
         7'h00: m_data = wd;
         7'h04: m_ctrl = wd[7:0];
         7'h08: m_dp = wd[7:0];
`ifdef SEVENSEG_BRIGHTNESS_EN
         7'h0C: m_bright = wd[3:0];
`endif
         default: ;
      endcase
   endtask

   task automatic do_read(input logic [31:0] addr, output logic [31:0] rdv);
      logic err;
      apb(1'b0, addr, 32'h0, rdv, err);
      chk($sformatf("rd_err@%h", addr[6:0]), {31'h0, err}, {31'h0, !off_valid(addr[6:0])});
      chk($sformatf("rd_data@%h", addr[6:0]), rdv, model_val(addr[6:0]));
   endtask

   task automatic check_disp(input int ncyc);
      for (int k = 0; k < ncyc; k++) begin
         @(negedge pCLK);
         chk($sformatf("disp n=%0d", n), {16'h0, an, seg, dp}, {16'h0, exp_disp(n)});
      end
   endtask

   // Stop at the negedge where the pins show slot i, div_cnt 0.
   task automatic wait_slot(input int i);
      bit hit = 1'b0;
      for (int k = 0; k < FRAME + 4 && !hit; k++) begin
         @(negedge pCLK);
         if (n > 0 && ((n - 1) % FRAME) == i * SD) hit = 1'b1;
      end
      chk($sformatf("wait_slot%0d", i), {31'h0, hit}, 32'h1);
   endtask

   initial begin
      logic [31:0] rv;
      pRESET = 1'b1; pSEL = 0; pENABLE = 0; pWRITE = 0; pADDR = 0; pWDATA = 0;
      model_reset();
      repeat (3) @(negedge pCLK);
      chk("rst_an", {24'h0, an}, 32'hFF);
      chk("rst_seg", {25'h0, seg}, 32'h7F);
      chk("rst_dp", {31'h0, dp}, 32'h1);
      chk("rst_ready", {31'h0, pREADY}, 32'h1);
      chk("rst_slverr", {31'h0, pSLVERR}, 32'h0);
      chk("rst_rdata", pRDATA, 32'h0);
      pRESET = 1'b0;
      do_read(32'h00, rv);
      do_read(32'h04, rv);
      do_read(32'h08, rv);
      do_read(32'h0C, rv);

      // All digits, DP on digit 0.
      do_write(32'h00, 32'h89AB_CDEF);
      do_write(32'h04, 32'h0000_00FF);
      do_write(32'h08, 32'h0000_0001);
      wait_slot(0);
      chk("slot0", {16'h0, an, seg, dp}, {16'h0, 8'hFE, 7'h0E, 1'b0});
      wait_slot(1);
      chk("slot1", {16'h0, an, seg, dp}, {16'h0, 8'hFD, 7'h06, 1'b1});
      wait_slot(7);
      chk("slot7", {16'h0, an, seg, dp}, {16'h0, 8'h7F, 7'h00, 1'b1});
      check_disp(FRAME + 8);

      do_read(32'h00, rv);
      chk("rd_data_const", rv, 32'h89AB_CDEF);
      do_read(32'h04, rv);
      chk("rd_ctrl_const", rv, 32'h0000_00FF);
      do_read(32'h08, rv);
      chk("rd_dp_const", rv, 32'h0000_0001);

      // Invalid offsets leave state untouched.
      do_write(32'h10, 32'hDEAD_BEEF);
      do_write(32'h7C, 32'h1234_5678);
      do_read(32'h10, rv);
      do_read(32'h7C, rv);
      do_read(32'h0C, rv);
      do_read(32'h00, rv);
      chk("data_kept", rv, 32'h89AB_CDEF);

      // Sparse enable mask.
      do_write(32'h04, 32'h0000_0005);
      do_write(32'h00, 32'h0000_0000);
      wait_slot(0);
      chk("sparse_s0", {24'h0, an}, 32'hFE);
      wait_slot(1);
      chk("sparse_s1", {24'h0, an}, 32'hFF);
      wait_slot(2);
      chk("sparse_s2", {17'h0, an, seg}, {17'h0, 8'hFB, 7'h40});
      wait_slot(3);
      chk("sparse_s3", {24'h0, an}, 32'hFF);
      check_disp(FRAME);

      do_write(32'h04, 32'hFFFF_FF0F);
      do_read(32'h04, rv);
      chk("ctrl_mask", rv, 32'h0000_000F);

`ifdef SEVENSEG_BRIGHTNESS_EN
      do_write(32'h0C, 32'hFFFF_FFF3);
      do_write(32'h04, 32'h0000_00FF);
      do_read(32'h0C, rv);
      chk("bright_rd", rv, 32'h3);
      wait_slot(2);
      for (int d = 0; d < SD; d++) begin
         chk($sformatf("dim d=%0d", d), {24'h0, an}, (d < 8) ? 32'hFB : 32'hFF);
         @(negedge pCLK);
      end
      check_disp(FRAME + 4);
      do_write(32'h0C, 32'h0000_000F);
`endif

      // Reset in the middle of a lit slot.
      do_write(32'h04, 32'h0000_00FF);
      wait_slot(3);
      repeat (2) @(negedge pCLK);
      chk("pre_rst_an", {24'h0, an}, 32'hF7);
      pRESET = 1'b1;
      @(negedge pCLK);
      chk("midrst_an", {24'h0, an}, 32'hFF);
      model_reset();
      pRESET = 1'b0;
      do_read(32'h04, rv);
      do_read(32'h0C, rv);
      check_disp(8);

      // Random register contents and decode-qualified addresses.
      for (int r = 0; r < 5; r++) begin
         logic [6:0] off;
         do_write(($urandom & 32'hFFFF_FF80) | 32'h00, $urandom);
         do_write(($urandom & 32'hFFFF_FF80) | 32'h04, $urandom);
         do_write(($urandom & 32'hFFFF_FF80) | 32'h08, $urandom);
`ifdef SEVENSEG_BRIGHTNESS_EN
         do_write(($urandom & 32'hFFFF_FF80) | 32'h0C, $urandom);
`endif
         off = 7'($urandom_range(0, 127));
         do_write({25'h0, off}, $urandom);
         for (int k = 0; k < 3; k++) begin
            off = (k == 2) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 3) * 4);
            do_read(($urandom & 32'hFFFF_FF80) | {25'h0, off}, rv);
         end
         check_disp(FRAME + 3);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/apb_sevenseg.md
Name: apb_sevenseg

Overview:
- APB slave peripheral driving an 8-digit, multiplexed, common-anode seven-segment display.
- Sits on the same APB bus as the GPIO slave, as the next peripheral in the MCS SevenSeg design.
- Software writes eight hex nibbles, a digit-enable mask and decimal points.
- The block time-multiplexes the digits, decodes hex to segments and drives the anode/segment pins.

Parameters:
DW, 32, APB data width (only 32 supported)
AW, 32, APB address width; only pADDR[6:0] is decoded
SCAN_DIV, 100000, pCLK cycles per digit slot (1 ms at 100 MHz); must be a multiple of 16 and >= 16

Ports:
pCLK  in  1  clock
pRESET  in  1  synchronous, active-high reset
pADDR  in  AW  APB address
pSEL  in  1  APB select
pENABLE  in  1  APB enable
pWRITE  in  1  1=write, 0=read
pWDATA  in  DW  write data
pRDATA  out  DW  read data
pREADY  out  1  always 1 after reset
pSLVERR  out  1  error response for invalid offset
an  out  8  digit anodes, active-low, an[i]=digit i
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low

Behaviour:
- One clock (pCLK); reset is synchronous and active-high (pRESET).
- Access phase: acc = pSEL & pENABLE & pREADY. wr = acc & pWRITE; rd = acc & !pWRITE. Zero wait states.
- Register map (pADDR[6:0]):
  - 0x00 DATA, 32 bits, R/W; nibble i is digit i.
  - 0x04 CTRL, R/W; [7:0] digit enable mask; other bits write-ignored, read 0.
  - 0x08 DP, R/W; [7:0] decimal point i lit when bit i = 1; other bits read 0.
  - 0x0C BRIGHT: see Optional Feature.
- Writes: full-word, no byte strobes. Register updates on the pCLK edge ending the access phase.
- Reads: pRDATA is combinational. It carries the register value when rd and the offset is valid; otherwise 32'h0.
- pSLVERR is combinational. It is 1 when acc and the offset is invalid; otherwise 0. An invalid write changes no state.
- Reset values:
  - DATA = 0, CTRL = 0, DP = 0, BRIGHT = 15.
  - pREADY = 1, pSLVERR = 0, pRDATA = 0.
  - an = 8'hFF, seg = 7'h7F, dp = 1.
  - div_cnt = 0, idx = 0.
- Scan counter:
  - div_cnt counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1, div_cnt wraps to 0 and idx (3-bit) increments, wrapping 7 -> 0.
  - Scanning runs continuously from reset, independent of APB traffic.
- Outputs are registered, one cycle latency from idx/div_cnt/registers:
  - If CTRL[idx] = 1 and lit: an = ~(1 << idx), seg = hex(DATA[4*idx+:4]), dp = ~DP[idx].
  - Otherwise: an = 8'hFF, seg = 7'h7F, dp = 1.
- Hex decode, active-low, nibble 0..F: 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E.
- Simultaneous write and slot advance: the output register samples the old register value that cycle and the new value from the next cycle. No glitch beyond one cycle.
- Reset mid-frame: everything returns to reset values on the next edge and the display blanks immediately.
- Exactly one anode is low at any time, or none.

Optional Feature:
- Macro: SEVENSEG_BRIGHTNESS_EN.
- With the macro defined:
  - 0x0C BRIGHT is valid. [3:0] = level B, reset 15; other bits read 0.
  - Each slot is split into 16 sub-phases of SCAN_DIV/16 cycles; sub = div_cnt / (SCAN_DIV/16).
  - lit = (sub <= B). B = 15 means always lit; B = 0 means lit 1/16 of the slot.
- Without the macro:
  - 0x0C is an invalid offset: pSLVERR = 1, read returns 0.
  - lit is always 1.

Test Plan:
- Reset, SCAN_DIV=16 -> an=FF, seg=7F, dp=1, pREADY=1, pSLVERR=0; all registers read 0, BRIGHT reads 15 with the macro.
- Write DATA=32'h89ABCDEF, CTRL=FF, DP=01 -> slot idx0 gives an=FE, seg=0E, dp=0. idx1 gives an=FD, seg=06, dp=1. idx7 gives an=7F, seg=00. After 128 cycles the pattern repeats at idx0.
- CTRL=8'h05, DATA=0 -> an=FE for slot 0, FF for slot 1, FB for slot 2 with seg=40, FF for slots 3-7.
- Read 0x00/0x04/0x08 after writes -> pRDATA=89ABCDEF/000000FF/00000001 in the access cycle, pSLVERR=0. Write CTRL=32'hFFFF_FF0F, read back -> 0000000F.
- Write/read 0x10 and 0x7C -> pSLVERR=1, pRDATA=0, DATA/CTRL/DP unchanged. Read 0x0C without the macro -> pSLVERR=1.
- With SEVENSEG_BRIGHTNESS_EN, SCAN_DIV=32, BRIGHT=3, CTRL=FF -> per slot, an is active for div_cnt 0..7 and FF for div_cnt 8..31. Assert pRESET mid-slot -> next edge an=FF and BRIGHT=15.
